alu_mc: RTL and testbench



---
 rtl/alu_mc.sv | 213 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle execution unit: single-cycle ALU/address ops plus iterative
// unsigned shift-add multiply and restoring divide behind valid/ready handshakes.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] npc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_o,
    output logic [WIDTH-1:0] alu_hi,
    output logic [WIDTH-1:0] addr_o,
    output logic             ife
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
    localparam logic [OPW-1:0] OP_AND  = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6'b000011);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_MULU = OPW'(6'b000110);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(6'b000111);
    localparam logic [OPW-1:0] OP_SW   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_LW   = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b100000);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(6'b100001);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [OPW-1:0]     op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   alu_o_r;
    logic [WIDTH-1:0]   alu_hi_r;
    logic [WIDTH-1:0]   addr_o_r;
    logic               ife_r;

    logic               is_multi_s;
    logic [WIDTH-1:0]   sc_lo_s;
    logic [WIDTH-1:0]   sc_addr_s;
    logic               sc_ife_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   iter_hi_s;
    logic [WIDTH-1:0]   iter_lo_s;

    assign is_multi_s = (op == OP_MULU) || (op == OP_DIVU);
    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == DONE);
    assign alu_o      = alu_o_r;
    assign alu_hi     = alu_hi_r;
    assign addr_o     = addr_o_r;
    assign ife        = ife_r;

    // Single-cycle result decode from the live operands at the accept edge.
    always_comb begin
        sc_lo_s   = {WIDTH{1'b0}};
        sc_addr_s = {WIDTH{1'b0}};
        sc_ife_s  = 1'b0;
        case (op)
            OP_ADD:  sc_lo_s = A + B;
            OP_SUB:  sc_lo_s = A - B;
            OP_AND:  sc_lo_s = A & B;
            OP_OR:   sc_lo_s = A | B;
            OP_XOR:  sc_lo_s = A ^ B;
            OP_SLT:  sc_lo_s = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SW: begin
                sc_lo_s   = B;
                sc_addr_s = A + Imm;
            end
            OP_LW:   sc_addr_s = A + Imm;
            OP_BEQ: begin
                sc_addr_s = (Imm << 2'd2) + npc;
                sc_ife_s  = (A == {WIDTH{1'b0}});
            end
            OP_JMP:  sc_addr_s = (Imm << 2'd2) + npc;
            default: begin
                sc_lo_s   = {WIDTH{1'b0}};
                sc_addr_s = {WIDTH{1'b0}};
                sc_ife_s  = 1'b0;
            end
        endcase
    end

    // One multiply or divide step; a clear borrow bit means the trial subtract fits.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, b_r};
        div_ge_s    = ~div_diff_s[WIDTH];
        if (op_r == OP_MULU) begin
            iter_hi_s = mul_sum_s[WIDTH:1];
            iter_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end else begin
            iter_hi_s = div_ge_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
            iter_lo_s = {lo_r[WIDTH-2:0], div_ge_s};
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = is_multi_s ? BUSY : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= {OPW{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            alu_o_r  <= {WIDTH{1'b0}};
            alu_hi_r <= {WIDTH{1'b0}};
            addr_o_r <= {WIDTH{1'b0}};
            ife_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r  <= op;
                        a_r   <= A;
                        b_r   <= B;
                        cnt_r <= {CW{1'b0}};
                        hi_r  <= {WIDTH{1'b0}};
                        lo_r  <= (op == OP_MULU) ? B : A;
                        if (!is_multi_s) begin
                            alu_o_r  <= sc_lo_s;
                            alu_hi_r <= {WIDTH{1'b0}};
                            addr_o_r <= sc_addr_s;
                            ife_r    <= sc_ife_s;
                        end
                    end
                end
                BUSY: begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    hi_r  <= iter_hi_s;
                    lo_r  <= iter_lo_s;
                    if (cnt_r == CNT_LAST) begin
                        alu_o_r  <= iter_lo_s;
                        alu_hi_r <= iter_hi_s;
                        addr_o_r <= {WIDTH{1'b0}};
                        ife_r    <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        cnt_r <= {CW{1'b0}};
                    end
                end
                default: cnt_r <= {CW{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc: expected results are queued at accept
// and compared with immediate assertions when out_valid is seen.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [31:0] npc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_o;
    logic [31:0] alu_hi;
    logic [31:0] addr_o;
    logic        ife;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] addr;
        logic        ife;
    } exp_t;

    exp_t sb[$];

    alu_mc #(.WIDTH(32), .OPW(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .npc(npc), .A(a), .B(b), .Imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_o(alu_o), .alu_hi(alu_hi), .addr_o(addr_o), .ife(ife)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] o, input logic [31:0] n,
                                   input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] im);
        exp_t e;
        logic [63:0] p;
        e = '0;
        p = 64'd0;
        case (o)
            6'd0:  e.lo = x + y;
            6'd1:  e.lo = x - y;
            6'd2:  e.lo = x & y;
            6'd3:  e.lo = x | y;
            6'd4:  e.lo = x ^ y;
            6'd5:  e.lo = (x < y) ? 32'd1 : 32'd0;
            6'd6: begin
                p = {32'd0, x} * {32'd0, y};
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            6'd7: begin
                if (y == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = x;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
            6'd16: begin
                e.lo   = y;
                e.addr = x + im;
            end
            6'd17: e.addr = x + im;
            6'd32: begin
                e.addr = (im << 2) + n;
                e.ife  = (x == 32'd0);
            end
            6'd33: e.addr = (im << 2) + n;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [5:0] o, input logic [31:0] n, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] im, input int hold);
        exp_t e;
        int   lat;
        int   exp_lat;
        logic rdy_seen;
        exp_lat = (o == 6'd6 || o == 6'd7) ? 33 : 1;
        @(negedge clk);
        out_ready = (hold == 0);
        op = o; npc = n; a = x; b = y; imm = im; in_valid = 1'b1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        sb.push_back(model(o, n, x, y, im));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 6'($urandom); npc = $urandom; a = $urandom; b = $urandom; imm = $urandom;
        lat = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready && !out_valid) rdy_seen = 1'b1;
        end while (!out_valid && lat < 100);
        check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
        check("latency", lat, exp_lat);
        check("in_ready_busy", {31'd0, rdy_seen}, 32'd0);
        e = sb.pop_front();
        check("alu_o", alu_o, e.lo);
        check("alu_hi", alu_hi, e.hi);
        check("addr_o", addr_o, e.addr);
        check("ife", {31'd0, ife}, {31'd0, e.ife});
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            op = 6'd0; a = $urandom; b = $urandom;
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_alu_o", alu_o, e.lo);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_valid", {31'd0, out_valid}, 32'd0);
        check("handoff_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [5:0] sc_ops [0:10];
        sc_ops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd16, 6'd17, 6'd32, 6'd33, 6'd63};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 6'd0; npc = 32'd0; a = 32'd0; b = 32'd0; imm = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_o", alu_o, 32'd0);
        check("rst_alu_hi", alu_hi, 32'd0);
        check("rst_addr_o", addr_o, 32'd0);
        check("rst_ife", {31'd0, ife}, 32'd0);
        rst = 1'b0;

        run_op(6'd0, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0);
        run_op(6'd32, 32'h100, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(6'd32, 32'h100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(6'd6, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(6'd7, 32'd0, 32'd100, 32'd7, 32'd0, 0);
        run_op(6'd7, 32'd0, 32'h1234, 32'd0, 32'd0, 0);
        run_op(6'd5, 32'd0, 32'd3, 32'd5, 32'd0, 4);

        // Reset in the middle of a multiply discards it and zeroes the outputs.
        @(negedge clk);
        op = 6'd6; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_alu_o", alu_o, 32'd0);
        check("midrst_alu_hi", alu_hi, 32'd0);
        check("midrst_addr_o", addr_o, 32'd0);
        run_op(6'd0, 32'd0, 32'd1, 32'd1, 32'd0, 0);

        for (int i = 0; i < 11; i++) begin
            run_op(sc_ops[i], $urandom, $urandom, $urandom, $urandom, i % 2);
        end
        run_op(6'd6, 32'd0, $urandom, $urandom, 32'd0, 1);
        run_op(6'd7, 32'd0, $urandom, 32'($urandom_range(1, 1000)), 32'd0, 0);
        run_op(6'd7, 32'd0, 32'd5, 32'd9, 32'd0, 0);
        check("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
